// File: rtl/instr_enc_pkg.sv
// instr_enc_pkg: format codes, constants and the pack/range-check function for the encoder
package instr_enc_pkg;
  typedef enum logic [2:0] {EXT_I = 3'd0, EXT_U = 3'd1, EXT_S = 3'd2, EXT_B = 3'd3, EXT_J = 3'd4} ext_op_e;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int FIFO_DEPTH = 2;
  typedef struct packed {
    logic err;
    logic [31:0] instr;
  } enc_t;
  function automatic logic fits(input logic [31:0] v, input int unsigned msb);
    logic [31:0] t;
    t = 32'($signed(v) >>> msb);
    return t == '0 || t == '1;
  endfunction
  function automatic enc_t encode(input logic [2:0] op, input logic [6:0] opcode, input logic [2:0] funct3,
                                  input logic [6:0] funct7, input logic shamt, input logic [4:0] rd, rs1, rs2,
                                  input logic [31:0] imm);
    enc_t r;
    r.err = 1'b1;
    r.instr = NOP;
    case (op)
      EXT_I: begin
        r.instr = shamt ? {funct7, imm[4:0], rs1, funct3, rd, opcode} : {imm[11:0], rs1, funct3, rd, opcode};
        r.err = shamt ? |imm[31:5] : !fits(imm, 11);
      end
      EXT_U: begin
        r.instr = {imm[31:12], rd, opcode};
        r.err = |imm[11:0];
      end
      EXT_S: begin
        r.instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        r.err = !fits(imm, 11);
      end
      EXT_B: begin
        r.instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        r.err = imm[0] || !fits(imm, 12);
      end
      EXT_J: begin
        r.instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        r.err = imm[0] || !fits(imm, 20);
      end
      default: ;
    endcase
    return r;
  endfunction
endpackage

// File: rtl/instr_encoder_if.sv
// instr_encoder_if: request fields and result handshake between a requester and the encoder
interface instr_encoder_if;
  logic in_valid, in_ready;
  logic [2:0] ext_op;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic imm_is_shamt;
  logic [4:0] rd, rs1, rs2;
  logic [31:0] imm;
  logic out_valid, out_ready;
  logic [31:0] instr;
  logic err;
  modport master (output in_valid, ext_op, opcode, funct3, funct7, imm_is_shamt, rd, rs1, rs2, imm, out_ready,
                  input in_ready, out_valid, instr, err);
  modport slave (input in_valid, ext_op, opcode, funct3, funct7, imm_is_shamt, rd, rs1, rs2, imm, out_ready,
                 output in_ready, out_valid, instr, err);
endinterface

// File: rtl/enc_fifo2.sv
// enc_fifo2: two-entry result buffer holding {err, instr}
module enc_fifo2 import instr_enc_pkg::*; (
  input  logic clk,
  input  logic rstn,
  input  logic push,
  input  logic pop,
  input  enc_t din,
  output enc_t dout,
  output logic [1:0] cnt
);
  enc_t mem [FIFO_DEPTH];
  logic wp, rp;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp <= !wp;
      end
      if (pop) rp <= !rp;
      cnt <= cnt + 2'(push) - 2'(pop);
    end
  assign dout = mem[rp];
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: packs RV32 instruction fields with range checks into a 2-deep result buffer
module instr_encoder import instr_enc_pkg::*; #(
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rstn,
  instr_encoder_if.slave bus,
  output logic [CNT_W-1:0] enc_cnt,
  output logic [CNT_W-1:0] err_cnt
);
  enc_t enc, head;
  logic [1:0] cnt;
  logic live, accept;
  always_comb enc = encode(bus.ext_op, bus.opcode, bus.funct3, bus.funct7, bus.imm_is_shamt,
                           bus.rd, bus.rs1, bus.rs2, bus.imm);
  // live holds in_ready low during reset and for no longer than the first edge after release
  assign bus.in_ready = live && cnt < 2'(FIFO_DEPTH);
  assign bus.out_valid = cnt != 2'd0;
  assign bus.instr = head.instr;
  assign bus.err = head.err;
  assign accept = bus.in_valid && bus.in_ready;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      live <= 1'b0;
      enc_cnt <= '0;
      err_cnt <= '0;
    end else begin
      live <= 1'b1;
      if (accept && !(&enc_cnt)) enc_cnt <= enc_cnt + CNT_W'(1);
      if (accept && enc.err && !(&err_cnt)) err_cnt <= err_cnt + CNT_W'(1);
    end
  enc_fifo2 u_fifo (
    .clk(clk),
    .rstn(rstn),
    .push(accept),
    .pop(bus.out_valid && bus.out_ready),
    .din(enc),
    .dout(head),
    .cnt(cnt)
  );
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed and randomized checks of instr_encoder against an arithmetic reference model
module tb_instr_encoder;
  localparam int CNT_W = 3;
  typedef struct {
    logic [2:0] op;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic sh;
    logic [4:0] rd, rs1, rs2;
    logic [31:0] imm;
    logic [31:0] ei;
    logic ee;
  } vec_t;
  logic clk = 1'b0, rstn = 1'b0;
  logic [CNT_W-1:0] enc_cnt, err_cnt;
  int n_tests = 0, n_fail = 0;
  vec_t v [11];
  instr_encoder_if bus ();
  instr_encoder #(.CNT_W(CNT_W)) dut (.clk(clk), .rstn(rstn), .bus(bus), .enc_cnt(enc_cnt), .err_cnt(err_cnt));
  always #5 clk = ~clk;

  function automatic int sat(input int n);
    return n > 7 ? 7 : n;
  endfunction

  // Field placement by shifting and masking the immediate arithmetically; ranges as signed bounds.
  function automatic logic [32:0] ref_enc(input vec_t x);
    longint s = $signed(x.imm);
    logic [31:0] u = x.imm;
    logic [31:0] w;
    logic e;
    case (x.op)
      3'd0: if (x.sh) begin
        w = 32'(x.f7) << 25 | (u % 32) << 20 | 32'(x.rs1) << 15 | 32'(x.f3) << 12 | 32'(x.rd) << 7 | 32'(x.opc);
        e = u >= 32;
      end else begin
        w = (u % 4096) << 20 | 32'(x.rs1) << 15 | 32'(x.f3) << 12 | 32'(x.rd) << 7 | 32'(x.opc);
        e = s < -2048 || s > 2047;
      end
      3'd1: begin
        w = (u / 4096) * 4096 | 32'(x.rd) << 7 | 32'(x.opc);
        e = u % 4096 != 0;
      end
      3'd2: begin
        w = ((u / 32) % 128) << 25 | 32'(x.rs2) << 20 | 32'(x.rs1) << 15 | 32'(x.f3) << 12 | (u % 32) << 7 | 32'(x.opc);
        e = s < -2048 || s > 2047;
      end
      3'd3: begin
        w = ((u / 4096) % 2) << 31 | ((u / 32) % 64) << 25 | 32'(x.rs2) << 20 | 32'(x.rs1) << 15 | 32'(x.f3) << 12 |
            ((u / 2) % 16) << 8 | ((u / 2048) % 2) << 7 | 32'(x.opc);
        e = u % 2 != 0 || s < -4096 || s > 4095;
      end
      3'd4: begin
        w = ((u / 1048576) % 2) << 31 | ((u / 2) % 1024) << 21 | ((u / 2048) % 2) << 20 | ((u / 4096) % 256) << 12 |
            32'(x.rd) << 7 | 32'(x.opc);
        e = u % 2 != 0 || s < -1048576 || s > 1048575;
      end
      default: begin
        w = 32'h13;
        e = 1'b1;
      end
    endcase
    return {e, w};
  endfunction

  task automatic put(input vec_t x);
    bus.ext_op = x.op;
    bus.opcode = x.opc;
    bus.funct3 = x.f3;
    bus.funct7 = x.f7;
    bus.imm_is_shamt = x.sh;
    bus.rd = x.rd;
    bus.rs1 = x.rs1;
    bus.rs2 = x.rs2;
    bus.imm = x.imm;
  endtask

  task automatic apply_reset();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    rstn = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    rstn = 1'b0;
    #3;
    n_tests += 4;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
    if ({bus.err, bus.instr} !== 33'd0) begin n_fail++; $display("FAIL reset_result: got %h want 0", {bus.err, bus.instr}); end
    if ({enc_cnt, err_cnt} !== '0) begin n_fail++; $display("FAIL reset_counters: got %0d/%0d want 0/0", enc_cnt, err_cnt); end
    @(negedge clk) rstn = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_vectors();
    apply_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      put(v[i]);
      bus.in_valid = 1'b1;
      n_tests++;
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL vec%0d_in_ready: got %b want 1", i, bus.in_ready); end
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      n_tests += 2;
      if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL vec%0d_latency: out_valid got %b want 1", i, bus.out_valid); end
      if ({bus.err, bus.instr} !== {v[i].ee, v[i].ei})
        begin n_fail++; $display("FAIL vec%0d_result: got err=%b instr=%h want err=%b instr=%h", i, bus.err, bus.instr, v[i].ee, v[i].ei); end
      if (i == 3) begin
        n_tests++;
        if (err_cnt !== 3'd1) begin n_fail++; $display("FAIL jal_misaligned_err_cnt: got %0d want 1", err_cnt); end
      end
      @(posedge clk);
      #1;
    end
    n_tests += 2;
    if (enc_cnt !== 3'(sat(11))) begin n_fail++; $display("FAIL vec_enc_cnt_saturate: got %0d want %0d", enc_cnt, sat(11)); end
    if (err_cnt !== 3'd5) begin n_fail++; $display("FAIL vec_err_cnt: got %0d want 5", err_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [32:0] exp [3];
    int got = 0;
    exp[0] = {v[0].ee, v[0].ei};
    exp[1] = {v[1].ee, v[1].ei};
    exp[2] = {v[8].ee, v[8].ei};
    apply_reset();
    put(v[0]);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 put(v[1]);
    n_tests++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_after_1: got %b want 1", bus.in_ready); end
    @(posedge clk);
    #1 put(v[8]);
    n_tests++;
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_after_2: got %b want 0", bus.in_ready); end
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      n_tests += 2;
      if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_third_held: in_ready got %b want 0", bus.in_ready); end
      if ({bus.err, bus.instr} !== exp[0]) begin n_fail++; $display("FAIL b2b_stable_head: got %h want %h", {bus.err, bus.instr}, exp[0]); end
    end
    bus.out_ready = 1'b1;
    for (int c = 0; c < 10 && got < 3; c++) begin
      automatic logic acc = bus.in_valid && bus.in_ready;
      if (bus.out_valid) begin
        n_tests++;
        if ({bus.err, bus.instr} !== exp[got])
          begin n_fail++; $display("FAIL b2b_order%0d: got %h want %h", got, {bus.err, bus.instr}, exp[got]); end
        got++;
      end
      @(posedge clk);
      #1 if (acc) bus.in_valid = 1'b0;
    end
    n_tests += 2;
    if (got !== 3) begin n_fail++; $display("FAIL b2b_drain_count: got %0d want 3", got); end
    if (enc_cnt !== 3'd3) begin n_fail++; $display("FAIL b2b_enc_cnt: got %0d want 3", enc_cnt); end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    put(v[4]);
    bus.in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 bus.in_valid = 1'b0;
    n_tests++;
    if (bus.out_valid !== 1'b1 || enc_cnt !== 3'd2)
      begin n_fail++; $display("FAIL mid_prefill: out_valid=%b enc_cnt=%0d want 1/2", bus.out_valid, enc_cnt); end
    #2 rstn = 1'b0;
    #1;
    n_tests += 3;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_async_out_valid: got %b want 0", bus.out_valid); end
    if ({enc_cnt, err_cnt} !== '0) begin n_fail++; $display("FAIL mid_async_counters: got %0d/%0d want 0/0", enc_cnt, err_cnt); end
    if ({bus.in_ready, bus.err, bus.instr} !== 34'd0)
      begin n_fail++; $display("FAIL mid_async_outputs: got %h want 0", {bus.in_ready, bus.err, bus.instr}); end
    #1 rstn = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
      begin n_fail++; $display("FAIL mid_release: in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid); end
  endtask

  task automatic test_random();
    logic [32:0] q [$];
    int n_acc = 0, n_err = 0;
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      vec_t x;
      logic [31:0] r = $urandom;
      logic do_push, do_pop;
      logic [32:0] e;
      x.op = ($urandom % 10 < 8) ? 3'($urandom % 5) : 3'(5 + $urandom % 3);
      x.opc = 7'($urandom);
      x.f3 = 3'($urandom);
      x.f7 = 7'($urandom);
      x.sh = 1'($urandom);
      x.rd = 5'($urandom);
      x.rs1 = 5'($urandom);
      x.rs2 = 5'($urandom);
      case ($urandom % 5)
        0: x.imm = r;
        1: x.imm = {{20{r[11]}}, r[11:0]};
        2: x.imm = {{19{r[12]}}, r[12:1], 1'b0};
        3: x.imm = {{11{r[20]}}, r[20:0]};
        default: x.imm = r & 32'h3F;
      endcase
      put(x);
      bus.in_valid = ($urandom % 4) != 0;
      bus.out_ready = ($urandom % 3) != 0;
      #1;
      n_tests += 2;
      if (bus.out_valid !== (q.size() != 0)) begin n_fail++; $display("FAIL rnd%0d_out_valid: got %b want %b", c, bus.out_valid, q.size() != 0); end
      if (bus.in_ready !== (q.size() < 2)) begin n_fail++; $display("FAIL rnd%0d_in_ready: got %b want %b", c, bus.in_ready, q.size() < 2); end
      do_pop = q.size() != 0 && bus.out_ready;
      do_push = bus.in_valid && q.size() < 2;
      if (do_pop) begin
        n_tests++;
        if ({bus.err, bus.instr} !== q[0])
          begin n_fail++; $display("FAIL rnd%0d_result: got err=%b instr=%h want err=%b instr=%h", c, bus.err, bus.instr, q[0][32], q[0][31:0]); end
      end
      e = ref_enc(x);
      @(posedge clk);
      #1;
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        q.push_back(e);
        n_acc++;
        n_err += int'(e[32]);
      end
    end
    bus.in_valid = 1'b0;
    n_tests += 2;
    if (enc_cnt !== 3'(sat(n_acc))) begin n_fail++; $display("FAIL rnd_enc_cnt: got %0d want %0d", enc_cnt, sat(n_acc)); end
    if (err_cnt !== 3'(sat(n_err))) begin n_fail++; $display("FAIL rnd_err_cnt: got %0d want %0d", err_cnt, sat(n_err)); end
  endtask

  initial begin
    v[0]  = '{3'd0, 7'h13, 3'd0, 7'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5,        32'h0050_0093, 1'b0};
    v[1]  = '{3'd3, 7'h63, 3'd0, 7'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0};
    v[2]  = '{3'd4, 7'h6F, 3'd0, 7'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h800,       32'h0010_00EF, 1'b0};
    v[3]  = '{3'd4, 7'h6F, 3'd0, 7'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h801,       32'h0010_00EF, 1'b1};
    v[4]  = '{3'd0, 7'h13, 3'd0, 7'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h800,       32'h8000_0093, 1'b1};
    v[5]  = '{3'd7, 7'h13, 3'd0, 7'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5,        32'h0000_0013, 1'b1};
    v[6]  = '{3'd0, 7'h13, 3'd1, 7'd0, 1'b1, 5'd1, 5'd1, 5'd0, 32'd3,        32'h0030_9093, 1'b0};
    v[7]  = '{3'd0, 7'h13, 3'd1, 7'd0, 1'b1, 5'd1, 5'd1, 5'd0, 32'h20,       32'h0000_9093, 1'b1};
    v[8]  = '{3'd1, 7'h37, 3'd0, 7'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0};
    v[9]  = '{3'd1, 7'h37, 3'd0, 7'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5001, 32'h1234_52B7, 1'b1};
    v[10] = '{3'd2, 7'h23, 3'd2, 7'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8,        32'h0020_A423, 1'b0};
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    put(v[0]);
    test_reset();
    test_vectors();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter CNT_W, default 16, width of the encode/error counters.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rstn  input  1  reset; asynchronous, active-low.
REQ-004 in_valid  input  1  request fields valid.
REQ-005 in_ready  output  1  encoder can accept a request this cycle.
REQ-006 ext_op  input  3  format: 000 I, 001 U, 010 S, 011 B, 100 J; 101-111 invalid.
REQ-007 opcode  input  7  instr[6:0].
REQ-008 funct3  input  3  instr[14:12] (I/S/B only).
REQ-009 funct7  input  7  instr[31:25] for I-type only when imm_is_shamt=1.
REQ-010 imm_is_shamt  input  1  I-type shift: imm[4:0] is shamt, funct7 is placed in [31:25].
REQ-011 rd, rs1, rs2  input  5 each  register fields.
REQ-012 imm  input  32  full signed byte-offset/immediate value to pack.
REQ-013 out_valid  output  1  instr/err valid.
REQ-014 out_ready  input  1  consumer accepts when high with out_valid.
REQ-015 instr  output  32  packed instruction.
REQ-016 err  output  1  immediate out of range, misaligned, or invalid ext_op.
REQ-017 enc_cnt, err_cnt  output  CNT_W each  accepted requests / requests flagged err.

Function
REQ-018 Request accepted on edge where in_valid and in_ready both high; packed result enters a 2-entry output FIFO on that edge (latency 1: out_valid high next cycle if FIFO was empty).
REQ-019 in_ready = (FIFO count < 2), from registered state only; no combinational path from out_ready.
REQ-020 Result popped on edge where out_valid and out_ready high; push and pop same edge with count 1 leaves count 1.
REQ-021 FIFO order strictly preserved; instr/err stable while out_valid high and out_ready low.
REQ-022 Packing is inverse of decode: I {imm[11:0],rs1,funct3,rd,opcode}; U {imm[31:12],rd,opcode}; S {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}; B {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}; J {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}.
REQ-023 Shift I-type: {funct7,imm[4:0],rs1,funct3,rd,opcode}; err if imm[31:5] != 0.
REQ-024 err for I/S when imm not sign-extension of imm[11:0]; U when imm[11:0] != 0; B when imm[0]=1 or not sign-extension of imm[12:0]; J when imm[0]=1 or not sign-extension of imm[20:0].
REQ-025 Invalid ext_op: err=1, instr=32'h0000_0013 (NOP); valid-format errors still pack low bits as per REQ-022.
REQ-026 enc_cnt increments per accepted request, err_cnt per accepted request with err=1; both saturate at all-ones.
REQ-027 Inputs ignored when in_valid low or in_ready low.

Reset
REQ-028 rstn low asynchronously clears FIFO count/pointers, out_valid=0, in_ready=0 while asserted, enc_cnt=0, err_cnt=0, instr=0, err=0.
REQ-029 Reset mid-operation discards buffered entries; in_ready=1 on first edge after rstn deasserts.

Structure
REQ-030 Shared package instr_enc_pkg holds ext_op codes (EXT_I..EXT_J), NOP constant 32'h0000_0013, FIFO depth 2.
REQ-031 Packing/range check is one combinational function block; 2-entry buffer is sub-module enc_fifo2 (data 33 bits: err+instr).

Verification
REQ-032 addi x1,x0,5: ext_op=000, opcode=0010011, funct3=0, rd=1, rs1=0, imm=5 -> instr=0x00500093, err=0, one cycle later.
REQ-033 beq x0,x0,-4: ext_op=011, opcode=1100011, funct3=0, imm=0xFFFFFFFC -> instr=0xFE000EE3, err=0.
REQ-034 jal x1,+2048: ext_op=100, opcode=1101111, rd=1, imm=0x800 -> instr=0x001000EF; imm=0x801 -> err=1, err_cnt=1.
REQ-035 I-type imm=0x800 -> err=1; ext_op=111 -> instr=0x00000013, err=1.
REQ-036 out_ready=0, 3 back-to-back requests -> in_ready low after 2nd accept, third held; out_ready=1 -> results in order, enc_cnt=3.
REQ-037 rstn pulsed low with 2 entries buffered -> out_valid=0, counters 0 immediately (no clk edge), in_ready=1 after release.
